// File: rtl/class_decision_unit_pkg.sv
// Shared constants and types for the keyword class decision stage.
// Class count and score width match the upstream dense layer output.
// Types: score_t (signed logit), cdu_state_t (decision FSM states).
package class_decision_unit_pkg;

  localparam int OUT_SIZE_4 = 3;
  localparam int SCORE_W    = 48;
  localparam int CLS_W      = $clog2(OUT_SIZE_4);

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DECIDE
  } cdu_state_t;

endpackage

// File: rtl/class_decision_unit_if.sv
// Score-vector input handshake plus decision result outputs.
// master: frame producer / result consumer; slave: the decision unit.
// Signals: in_valid/in_ready/score_vector in, out_valid/class_id/class_score/confident/detected out.
interface class_decision_unit_if #(
  parameter int OUT_SIZE_4 = class_decision_unit_pkg::OUT_SIZE_4,
  parameter int SCORE_W    = class_decision_unit_pkg::SCORE_W,
  parameter int CLS_W      = class_decision_unit_pkg::CLS_W
);

  logic                                in_valid;
  logic                                in_ready;
  logic [OUT_SIZE_4-1:0][SCORE_W-1:0]  score_vector;
  logic                                out_valid;
  logic [CLS_W-1:0]                    class_id;
  logic [SCORE_W-1:0]                  class_score;
  logic                                confident;
  logic                                detected;

  modport master (
    output in_valid, score_vector,
    input  in_ready, out_valid, class_id, class_score, confident, detected
  );

  modport slave (
    input  in_valid, score_vector,
    output in_ready, out_valid, class_id, class_score, confident, detected
  );

endinterface

// File: rtl/class_decision_unit_streak_filter.sv
// Consecutive-frame stability filter: counts confident frames of the same class.
// Latency: detected is registered on the update strobe edge.
// Backpressure: none, evaluates one decision per i_update pulse.
// Ports: clk, rst_n, i_update (strobe), i_class, i_confident, o_detected.
module streak_filter #(
  parameter int CLS_W       = 2,
  parameter int HOLD_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_update,
  input  logic [CLS_W-1:0] i_class,
  input  logic             i_confident,
  output logic             o_detected
);

  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CLS_W-1:0] r_prev_class;
  logic             r_prev_valid;
  logic             r_detected;

  // Count saturates at HOLD_FRAMES so detected stays up for a long streak.
  always_comb begin
    w_count_nxt = r_count;
    if (!i_confident) begin
      w_count_nxt = '0;
    end else if (r_prev_valid && (i_class == r_prev_class)) begin
      w_count_nxt = (r_count == HOLD_C) ? r_count : r_count + CNT_W'(1);
    end else begin
      w_count_nxt = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_prev_class <= '0;
      r_prev_valid <= 1'b0;
      r_detected   <= 1'b0;
    end else if (i_update) begin
      r_count    <= w_count_nxt;
      r_detected <= (w_count_nxt == HOLD_C);
      // Unconfident frames do not move the reference class.
      if (i_confident) begin
        r_prev_class <= i_class;
        r_prev_valid <= 1'b1;
      end
    end
  end

  assign o_detected = r_detected;

endmodule

// File: rtl/class_decision_unit.sv
// Argmax with runner-up tracking, confidence margin check and streak filter.
// Latency: out_valid pulses OUT_SIZE_4 edges after the accepting edge.
// Backpressure: in_ready only in IDLE; no output backpressure, outputs hold between pulses.
// Ports: clk, rst_n, bus (slave modport: in_valid/in_ready/score_vector, out_valid/class_id/class_score/confident/detected).
module class_decision_unit #(
  parameter int                 OUT_SIZE_4  = class_decision_unit_pkg::OUT_SIZE_4,
  parameter int                 SCORE_W     = class_decision_unit_pkg::SCORE_W,
  parameter logic [SCORE_W:0]   MARGIN      = '0,
  parameter int                 HOLD_FRAMES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  class_decision_unit_if.slave   bus
);

  import class_decision_unit_pkg::*;

  localparam int IDX_W = (OUT_SIZE_4 > 1) ? $clog2(OUT_SIZE_4) : 1;

  typedef logic signed [SCORE_W-1:0] sc_t;

  localparam sc_t SCORE_MIN = sc_t'({1'b1, {(SCORE_W-1){1'b0}}});

  cdu_state_t         r_state;
  cdu_state_t         w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic               w_decide;

  sc_t                r_scores [OUT_SIZE_4];
  sc_t                w_cur;
  sc_t                r_best;
  sc_t                r_second;
  logic [IDX_W-1:0]   r_best_idx;
  logic [IDX_W-1:0]   r_idx;

  logic signed [SCORE_W+1:0] w_diff;
  logic                      w_confident;

  logic               r_out_valid;
  logic [IDX_W-1:0]   r_class_id;
  sc_t                r_class_score;
  logic               r_confident;
  logic               w_detected;

  assign w_cur    = r_scores[r_idx];
  assign w_last   = (r_idx == IDX_W'(OUT_SIZE_4 - 1));
  assign w_decide = (r_state == DECIDE);

  // best >= second always holds, so the widened difference is non-negative.
  assign w_diff      = {{2{r_best[SCORE_W-1]}}, r_best} - {{2{r_second[SCORE_W-1]}}, r_second};
  assign w_confident = (w_diff >= $signed({1'b0, MARGIN}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (w_last) begin
          w_state_nxt = DECIDE;
        end
      end
      DECIDE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_SIZE_4; i++) begin
        r_scores[i] <= '0;
      end
      r_best        <= '0;
      r_second      <= '0;
      r_best_idx    <= '0;
      r_idx         <= '0;
      r_out_valid   <= 1'b0;
      r_class_id    <= '0;
      r_class_score <= '0;
      r_confident   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        for (int i = 0; i < OUT_SIZE_4; i++) begin
          r_scores[i] <= sc_t'(bus.score_vector[i]);
        end
        r_best     <= sc_t'(bus.score_vector[0]);
        r_best_idx <= '0;
        r_second   <= SCORE_MIN;
        r_idx      <= IDX_W'(1);
      end
      if (r_state == SCAN) begin
        // Strict compare: ties keep the lower index and land in second.
        if (w_cur > r_best) begin
          r_second   <= r_best;
          r_best     <= w_cur;
          r_best_idx <= r_idx;
        end else if (w_cur > r_second) begin
          r_second <= w_cur;
        end
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_decide) begin
        r_out_valid   <= 1'b1;
        r_class_id    <= r_best_idx;
        r_class_score <= r_best;
        r_confident   <= w_confident;
      end
    end
  end

  streak_filter #(
    .CLS_W       (IDX_W),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_streak (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_update    (w_decide),
    .i_class     (r_best_idx),
    .i_confident (w_confident),
    .o_detected  (w_detected)
  );

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.class_id    = r_class_id;
  assign bus.class_score = r_class_score;
  assign bus.confident   = r_confident;
  assign bus.detected    = w_detected;

endmodule

// File: tb/tb_class_decision_unit.sv
// Bench for class_decision_unit: two instances (MARGIN=0/HOLD=3 and MARGIN=1/HOLD=1)
// share one input stream; results are compared to a frame-level reference model.
// Ports: none (top-level bench).
module tb_class_decision_unit;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid;
  logic [2:0][47:0] sv;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nvalid   = 0;

  typedef struct {
    int     acc;
    int     cls;
    longint sc;
    bit     conf0;
    bit     det0;
    bit     conf1;
    bit     det1;
  } exp_t;

  exp_t   expq[$];
  exp_t   last_e;
  int     m_cnt[2];
  int     m_prev[2];
  bit     m_pv[2];
  int     m_hold[2]   = '{3, 1};
  longint m_margin[2] = '{0, 1};

  class_decision_unit_if #(.OUT_SIZE_4(3), .SCORE_W(48), .CLS_W(2)) if0 ();
  class_decision_unit_if #(.OUT_SIZE_4(3), .SCORE_W(48), .CLS_W(2)) if1 ();

  assign if0.in_valid     = in_valid;
  assign if0.score_vector = sv;
  assign if1.in_valid     = in_valid;
  assign if1.score_vector = sv;

  class_decision_unit #(.OUT_SIZE_4(3), .SCORE_W(48), .MARGIN(49'd0), .HOLD_FRAMES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  class_decision_unit #(.OUT_SIZE_4(3), .SCORE_W(48), .MARGIN(49'd1), .HOLD_FRAMES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rnd_score();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       return longint'($urandom_range(0, 6)) - 3;
      1:       return longint'($signed(r[47:0]));
      2:       return ($urandom_range(0, 1) == 1) ? (longint'(1) <<< 47) - 1 : -(longint'(1) <<< 47);
      default: return longint'($urandom_range(0, 200)) - 100;
    endcase
  endfunction

  // Frame-level reference: winner is the first maximum, runner-up is the
  // largest of the remaining scores; streak rules applied per instance.
  task automatic model_push(input longint a, input longint b, input longint c, input int acc);
    longint s[3];
    longint best;
    longint second;
    int     bi;
    bit     conf;
    exp_t   e;
    s = '{a, b, c};
    best = s[0];
    bi = 0;
    for (int i = 1; i < 3; i++) if (s[i] > best) begin best = s[i]; bi = i; end
    second = -(longint'(1) <<< 62);
    for (int i = 0; i < 3; i++) if (i != bi && s[i] > second) second = s[i];
    e.acc = acc;
    e.cls = bi;
    e.sc  = best;
    for (int d = 0; d < 2; d++) begin
      conf = ((best - second) >= m_margin[d]);
      if (!conf) m_cnt[d] = 0;
      else if (m_pv[d] && m_prev[d] == bi) m_cnt[d] = (m_cnt[d] + 1 > m_hold[d]) ? m_hold[d] : m_cnt[d] + 1;
      else m_cnt[d] = 1;
      if (conf) begin m_prev[d] = bi; m_pv[d] = 1'b1; end
      if (d == 0) begin e.conf0 = conf; e.det0 = (m_cnt[d] == m_hold[d]); end
      else begin e.conf1 = conf; e.det1 = (m_cnt[d] == m_hold[d]); end
    end
    expq.push_back(e);
  endtask

  task automatic model_clear();
    expq.delete();
    for (int d = 0; d < 2; d++) begin m_cnt[d] = 0; m_prev[d] = 0; m_pv[d] = 1'b0; end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_frame(input longint a, input longint b, input longint c, input bit keep, output int acc);
    int t;
    acc = -1;
    in_valid = 1'b1;
    sv[0] = a[47:0];
    sv[1] = b[47:0];
    sv[2] = c[47:0];
    t = 0;
    while (!if0.in_ready && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    model_push(a, b, c, acc);
    chk("in_ready_busy", if0.in_ready, 0);
    if (!keep) in_valid = 1'b0;
    // Scramble inputs: only the accepting edge may matter.
    sv[0] = 48'(rnd_score());
    sv[1] = 48'(rnd_score());
    sv[2] = 48'(rnd_score());
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() > 0 && t < 20) begin @(negedge clk); t++; end
    if (expq.size() > 0) chk("drain_timeout", expq.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ov"}, if0.out_valid, 0);
    chk({tag, "_cls"}, if0.class_id, 0);
    chk({tag, "_score"}, if0.class_score, 0);
    chk({tag, "_conf"}, if0.confident, 0);
    chk({tag, "_det"}, if0.detected, 0);
    chk({tag, "_det1"}, if1.detected, 0);
    chk({tag, "_rdy"}, if0.in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && (if0.out_valid || if1.out_valid)) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        last_e = e;
        nvalid++;
        chk("ov0", if0.out_valid, 1);
        chk("ov1", if1.out_valid, 1);
        chk("latency", cyc - e.acc, 3);
        chk("rdy_with_ov", if0.in_ready, 1);
        chk("cls0", if0.class_id, e.cls);
        chk("score0", $signed(if0.class_score), e.sc);
        chk("conf0", if0.confident, e.conf0);
        chk("det0", if0.detected, e.det0);
        chk("cls1", if1.class_id, e.cls);
        chk("score1", $signed(if1.class_score), e.sc);
        chk("conf1", if1.confident, e.conf1);
        chk("det1", if1.detected, e.det1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int prev_acc;
    int n0;
    in_valid = 1'b0;
    sv = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic argmax, tie handling, extreme negative scores.
    send_frame(10, 50, 20, 1'b0, acc);
    drain();
    chk("tp1_cls", if0.class_id, 1);
    chk("tp1_score", $signed(if0.class_score), 50);
    chk("tp1_det", if0.detected, 0);
    send_frame(7, 7, -3, 1'b0, acc);
    drain();
    send_frame(-(longint'(1) <<< 47), -1, -5, 1'b0, acc);
    drain();

    // Streak build-up and class change.
    for (int k = 0; k < 4; k++) begin
      send_frame(0, 0, 100, 1'b0, acc);
      drain();
    end
    chk("streak_det_sat", if0.detected, 1);
    send_frame(100, 0, 0, 1'b0, acc);
    drain();

    // Continuous in_valid: one accept every four cycles.
    prev_acc = -1;
    for (int k = 0; k < 20; k++) begin
      send_frame(rnd_score(), rnd_score(), rnd_score(), 1'b1, acc);
      if (prev_acc >= 0) chk("accept_spacing", acc - prev_acc, 4);
      prev_acc = acc;
    end
    in_valid = 1'b0;
    drain();

    // Random frames with idle gaps; small values make repeats likely.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(rnd_score(), rnd_score(), rnd_score(), 1'b0, acc);
    end
    drain();
    chk("hold_cls", if0.class_id, last_e.cls);
    chk("hold_score", $signed(if0.class_score), last_e.sc);

    // Reset during SCAN aborts the frame and clears the streak.
    send_frame(0, 0, 100, 1'b0, acc);
    send_frame(0, 0, 100, 1'b0, acc);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    n0 = nvalid;
    repeat (8) @(negedge clk);
    chk("no_ov_after_abort", nvalid, n0);
    send_frame(0, 0, 100, 1'b0, acc);
    drain();
    chk("post_reset_det", if0.detected, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/class_decision_unit.md
Name: class_decision_unit

Overview:
- Stage directly downstream of dense_layer_4.
- Takes the per-class score vector (OUT_SIZE_4 signed 48-bit logits) with a valid/ready handshake.
- Finds the winning class with a sequential argmax that also tracks the runner-up, then checks a confidence margin.
- Applies a consecutive-frame stability filter; produces the final keyword class id and a detection flag for the system.

Parameters:
- OUT_SIZE_4, 3, number of classes / scores per frame (from nn_parameters); must be >= 2
- SCORE_W, 48, signed score width
- MARGIN, 0, minimum (best - second) for a confident frame; unsigned, 49-bit
- HOLD_FRAMES, 3, consecutive confident frames of the same class required for detection; must be >= 1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  score_vector valid
- in_ready  out  1  block can accept a frame; high only in IDLE
- score_vector  in  SCORE_W x OUT_SIZE_4  signed class scores, index = class id
- out_valid  out  1  one-cycle pulse per processed frame
- class_id  out  CLS_W  argmax index of the last frame
- class_score  out  SCORE_W  winning score, signed
- confident  out  1  last frame had margin >= MARGIN
- detected  out  1  streak count == HOLD_FRAMES

Behaviour:
- Reset (async assert, sync release) clears all registered outputs to 0, streak count to 0, prev_class to 0 and prev_valid to 0, and puts the FSM in IDLE.
- FSM IDLE -> SCAN -> DECIDE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch all scores. Set best = score[0], best_idx = 0, second = -2^(SCORE_W-1), idx = 1. Go to SCAN.
- SCAN, one compare per cycle on score[idx]:
  - If s > best (strict): second <= best, best <= s, best_idx <= idx.
  - Else if s > second: second <= s.
  - Ties keep the lower index; a tied value becomes second, so margin = 0.
  - idx increments each cycle; after idx == OUT_SIZE_4-1 go to DECIDE.
- DECIDE:
  - diff = best - second, computed at SCORE_W+2 bits with no overflow. confident_n = (diff >= MARGIN).
  - Streak update:
    - If !confident_n: count <= 0.
    - Else if prev_valid and best_idx == prev_class: count <= min(count+1, HOLD_FRAMES).
    - Else: count <= 1.
    - If confident_n: prev_class <= best_idx and prev_valid <= 1.
  - Register class_id, class_score, confident, and detected = (new count == HOLD_FRAMES).
  - Pulse out_valid for 1 cycle. Return to IDLE.
- Latency: out_valid is high in the cycle starting OUT_SIZE_4 edges after the accepting edge (3 for the default).
- in_ready re-asserts in the same cycle as out_valid. Throughput is one frame per OUT_SIZE_4+1 cycles.
- There is no output backpressure. Output registers hold their values between pulses.
- in_valid while in_ready = 0 is ignored; the producer must hold it.
- score_vector is sampled only at the accepting edge; later changes have no effect.
- detected stays high while the streak continues (count saturates). It drops on the first unconfident frame or class change; a class change sets count to 1, so detected is 0 unless HOLD_FRAMES = 1.
- Reset mid-SCAN/DECIDE aborts the frame: no out_valid, streak is cleared, and in_ready = 1 after release.

Decomposition:
- nn_parameters package gains:
  - SCORE_W = 48
  - CLS_W = $clog2(OUT_SIZE_4)
  - typedef logic signed [SCORE_W-1:0] score_t
  - typedef enum {IDLE, SCAN, DECIDE} cdu_state_t
- Sub-module streak_filter holds count, prev_class and prev_valid.
  - Inputs: update strobe, class, confident.
  - Output: detected.
  - Same clk/rst_n.

Test Plan:
- Scores {10, 50, 20}, MARGIN=0 -> out_valid 3 cycles after accept; class_id=1, class_score=50, confident=1, detected=0 (count 1).
- Scores {7, 7, -3}, MARGIN=1 -> class_id=0, confident=0, count cleared; with MARGIN=0 -> confident=1.
- Scores {-2^47, -1, -5} -> class_id=1, class_score=-1; diff=4, no overflow.
- Four frames each {0, 0, 100}, HOLD_FRAMES=3 -> detected = 0, 0, 1, 1.
- Then a frame {100, 0, 0} -> class_id=0, detected=0.
- Assert in_valid continuously -> accepts exactly every 4 cycles; in_ready and out_valid high together.
- rst_n low during SCAN -> no out_valid, all outputs 0; the next frame {0, 0, 100} yields count 1 and detected=0.
